// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, field positions and prescaler helpers for timer_ctrl
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  localparam int TCR_LOAD    = 7;
  localparam int TCR_UD      = 5;
  localparam int TCR_EN      = 4;
  localparam int TCR_CKS_LSB = 0;
  localparam int TSR_OVF     = 0;
  localparam int TSR_UDF     = 1;

  // Bits of TCR that are stored and read back (UD, EN, CKS)
  localparam logic [7:0] TCR_RW_MASK = 8'h33;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  // On a free-running up counter, bit sel has just risen exactly when it is set
  // and every lower bit is clear; no history is needed, so changing sel cannot fake an edge.
  function automatic logic bit_rose(input logic [3:0] div, input logic [1:0] sel);
    logic rose;
    rose = 1'b0;
    case (sel)
      CKS_DIV2:  rose = div[0];
      CKS_DIV4:  rose = (div[1:0] == 2'b10);
      CKS_DIV8:  rose = (div[2:0] == 3'b100);
      CKS_DIV16: rose = (div[3:0] == 4'b1000);
      default:   rose = 1'b0;
    endcase
    return rose;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running 4-bit divider with registered rising-edge tick
module timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cks,
  output logic       clk_ena
);
  import timer_pkg::*;

  logic [3:0] r_div;
  logic       r_clk_ena;
  logic       w_rise;

  assign w_rise = bit_rose(r_div, cks);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= 4'd0;
      r_clk_ena <= 1'b0;
    end else begin
      r_div     <= r_div + 4'd1;
      r_clk_ena <= w_rise;
    end
  end

  assign clk_ena = r_clk_ena;

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - register front-end and strobe generation for the 8-bit timer counter
module timer_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              clk_ena,
  output logic [DATA_W-1:0] start_counter,
  output logic              up_down,
  output logic              load,
  output logic              enable,
  output logic              clr_overflow,
  output logic              clr_underflow,
  input  logic              overflow,
  input  logic              underflow,
  input  logic [DATA_W-1:0] tcnt
);
  import timer_pkg::*;

  logic [DATA_W-1:0] r_tdr;
  logic [DATA_W-1:0] r_tcr;
  logic              r_load;
  logic              r_clr_ovf;
  logic              r_clr_udf;

  logic              w_wr;
  logic              w_hit_tdr;
  logic              w_hit_tcr;
  logic              w_hit_tsr;
  logic              w_hit_tcnt;
  logic [DATA_W-1:0] w_rdata;

  assign w_wr       = psel & penable & pwrite;
  assign w_hit_tdr  = (paddr == ADDR_W'(ADDR_TDR));
  assign w_hit_tcr  = (paddr == ADDR_W'(ADDR_TCR));
  assign w_hit_tsr  = (paddr == ADDR_W'(ADDR_TSR));
  assign w_hit_tcnt = (paddr == ADDR_W'(ADDR_TCNT));

  // Strobes default low every cycle so each accepted write yields a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdr     <= '0;
      r_tcr     <= '0;
      r_load    <= 1'b0;
      r_clr_ovf <= 1'b0;
      r_clr_udf <= 1'b0;
    end else begin
      r_load    <= 1'b0;
      r_clr_ovf <= 1'b0;
      r_clr_udf <= 1'b0;
      if (w_wr) begin
        if (w_hit_tdr) begin
          r_tdr <= pwdata;
        end
        if (w_hit_tcr) begin
          r_tcr  <= pwdata & DATA_W'(TCR_RW_MASK);
          r_load <= pwdata[TCR_LOAD];
        end
        if (w_hit_tsr) begin
          r_clr_ovf <= pwdata[TSR_OVF];
          r_clr_udf <= pwdata[TSR_UDF];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (psel) begin
      if (w_hit_tdr)  w_rdata = r_tdr;
      if (w_hit_tcr)  w_rdata = r_tcr;
      if (w_hit_tsr)  w_rdata = {{(DATA_W-2){1'b0}}, underflow, overflow};
      if (w_hit_tcnt) w_rdata = tcnt;
    end
  end

  timer_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .cks     (r_tcr[TCR_CKS_LSB +: 2]),
    .clk_ena (clk_ena)
  );

  assign prdata        = w_rdata;
  assign pready        = 1'b1;
  assign start_counter = r_tdr;
  assign up_down       = r_tcr[TCR_UD];
  assign enable        = r_tcr[TCR_EN];
  assign load          = r_load;
  assign clr_overflow  = r_clr_ovf;
  assign clr_underflow = r_clr_udf;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed self-checking bench for timer_ctrl with a behavioural counter
module tb_timer_ctrl;
  import timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       clk_ena;
  logic [7:0] start_counter;
  logic       up_down;
  logic       load;
  logic       enable;
  logic       clr_overflow;
  logic       clr_underflow;
  logic       overflow;
  logic       underflow;
  logic [7:0] tcnt;

  int n_checks = 0;
  int n_errors = 0;
  int ena_seen;

  always #5 clk = ~clk;

  timer_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .clk_ena       (clk_ena),
    .start_counter (start_counter),
    .up_down       (up_down),
    .load          (load),
    .enable        (enable),
    .clr_overflow  (clr_overflow),
    .clr_underflow (clr_underflow),
    .overflow      (overflow),
    .underflow     (underflow),
    .tcnt          (tcnt)
  );

  // Behavioural 8-bit counter standing in for the real counter block
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= 8'h00;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ena_seen  <= 0;
    end else begin
      if (clr_overflow)  overflow  <= 1'b0;
      if (clr_underflow) underflow <= 1'b0;
      if (load) begin
        tcnt     <= start_counter;
        ena_seen <= 0;
      end else if (enable && clk_ena) begin
        ena_seen <= ena_seen + 1;
        if (up_down) begin
          tcnt <= tcnt + 8'd1;
          if (tcnt == 8'hFF) overflow <= 1'b1;
        end else begin
          tcnt <= tcnt - 8'd1;
          if (tcnt == 8'h00) underflow <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  task automatic wait_ena(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!clk_ena && cyc < 40);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int c;
    int glitches;
    int period;
    int found;

    // Reset state and first tick after release
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_outputs", {load, enable, up_down, clr_overflow, clr_underflow, clk_ena, start_counter}, 0);
    check("reset_pready", pready, 1);
    @(posedge clk); #1;
    check("reset_ena_cycle1", clk_ena, 0);
    @(posedge clk); #1;
    check("reset_ena_cycle2", clk_ena, 1);
    for (int a = 0; a < 4; a++) begin
      apb_read(8'(a), rd);
      check($sformatf("reset_read_%0d", a), rd, 0);
    end

    // Prescaler periods for every CKS setting
    for (int k = 0; k < 4; k++) begin
      period = 2 << k;
      apb_write(ADDR_TCR, 8'(k));
      wait_ena(c);
      check($sformatf("presc_sync_cks%0d", k), (c <= 17) ? 1 : 0, 1);
      for (int p = 0; p < 8; p++) begin
        @(posedge clk); #1;
        check($sformatf("presc_width_cks%0d", k), clk_ena, 0);
        wait_ena(c);
        check($sformatf("presc_period_cks%0d", k), c + 1, period);
      end
    end

    // CKS 0 -> 3 mid-period: tick aligned to divider value 8, then switch at divider 12
    wait_ena(c);
    apb_write(ADDR_TCR, 8'h00);
    apb_write(ADDR_TCR, 8'h03);
    check("cks_switch_e4", clk_ena, 0);
    glitches = 0;
    for (int i = 5; i < 16; i++) begin
      @(posedge clk); #1;
      if (clk_ena) glitches++;
    end
    check("cks_switch_glitches", glitches, 0);
    @(posedge clk); #1;
    check("cks_switch_next_tick", clk_ena, 1);

    // Load sequence
    apb_write(ADDR_TDR, 8'hFD);
    apb_write(ADDR_TCR, 8'hB0);
    check("load_pulse", load, 1);
    check("load_outputs", {start_counter, up_down, enable}, {8'hFD, 1'b1, 1'b1});
    @(posedge clk); #1;
    check("load_one_cycle", load, 0);
    apb_read(ADDR_TCR, rd);
    check("tcr_readback", rd, 8'h30);

    // Up-count from 0xFD until overflow
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (overflow) found = 1;
    end
    check("ovf_reached", found, 1);
    check("ovf_after_3_ticks", ena_seen, 3);
    apb_read(ADDR_TSR, rd);
    check("tsr_ovf_read", rd, 8'h01);
    apb_write(ADDR_TSR, 8'h01);
    check("clr_ovf_pulse", {clr_overflow, clr_underflow}, 2'b10);
    @(posedge clk); #1;
    check("clr_ovf_one_cycle", {clr_overflow, clr_underflow}, 2'b00);
    apb_read(ADDR_TSR, rd);
    check("tsr_cleared", rd, 8'h00);

    // LOAD with EN=0 still pulses
    apb_write(ADDR_TCR, 8'h80);
    check("load_en0_pulse", {load, enable, up_down}, 3'b100);
    @(posedge clk); #1;
    check("load_en0_one_cycle", load, 0);

    // Both clear strobes together, then a zero write gives none
    apb_write(ADDR_TSR, 8'h03);
    check("clr_both_pulse", {clr_overflow, clr_underflow}, 2'b11);
    @(posedge clk); #1;
    check("clr_both_one_cycle", {clr_overflow, clr_underflow}, 2'b00);
    apb_write(ADDR_TSR, 8'h00);
    check("clr_zero_write", {clr_overflow, clr_underflow}, 2'b00);

    // Unmapped and read-only writes leave state alone
    apb_write(8'h07, 8'h5A);
    check("unmapped_no_strobe", {load, clr_overflow, clr_underflow}, 3'b000);
    apb_write(ADDR_TCNT, 8'h11);
    apb_read(ADDR_TDR, rd);
    check("tdr_kept", rd, 8'hFD);
    apb_read(ADDR_TCR, rd);
    check("tcr_kept", rd, 8'h00);
    apb_read(8'h07, rd);
    check("unmapped_read", rd, 8'h00);
    apb_read(ADDR_TCNT, rd);
    check("tcnt_read", rd, 8'hFD);
    check("start_counter_kept", start_counter, 8'hFD);

    // Reset asserted while the load strobe is high
    apb_write(ADDR_TCR, 8'h90);
    check("pre_reset_load", load, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_drops_load", {load, enable, start_counter}, 0);
    check("reset_pready_mid", pready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rerelease_ena_cycle1", clk_ena, 0);
    @(posedge clk); #1;
    check("rerelease_ena_cycle2", clk_ena, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control and register front-end for the 8-bit timer `counter` block.
- Exposes a simple zero-wait-state APB-style register bus.
- Drives the counter's control inputs: start_counter, up_down, load, enable, clr_overflow, clr_underflow.
- Generates the counter's clk_ena tick from a selectable prescaler, divide by 2, 4, 8 or 16.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 8, bus data width; fixed at 8, matching the counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- psel  in  1  bus select.
- penable  in  1  bus access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  register address.
- pwdata  in  8  write data.
- prdata  out  8  read data.
- pready  out  1  always 1.
- clk_ena  out  1  one-cycle counting tick to the counter.
- start_counter  out  8  load value (TDR).
- up_down  out  1  1 = count up, 0 = count down.
- load  out  1  one-cycle load strobe.
- enable  out  1  count enable.
- clr_overflow  out  1  one-cycle clear strobe.
- clr_underflow  out  1  one-cycle clear strobe.
- overflow  in  1  sticky flag from the counter.
- underflow  in  1  sticky flag from the counter.
- tcnt  in  8  current counter value.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values: all registers and outputs 0, except pready=1. Prescaler count = 0.
- Bus write: occurs when psel & penable & pwrite. No wait states. Writes to unmapped addresses are ignored.
- Bus read: prdata is combinational from paddr when psel=1, otherwise 0. Unmapped addresses read 0.
- Register 0x00 TDR (RW): 8-bit start value, driven directly on start_counter.
- Register 0x01 TCR (RW):
  - bit7 LOAD: write-1 self-clearing, always reads 0.
  - bit5 UD: drives up_down.
  - bit4 EN: drives enable.
  - bits[1:0] CKS: prescaler select.
  - Other bits are write-ignored and read 0.
- Register 0x02 TSR:
  - Read: bit0 = overflow, bit1 = underflow, taken directly from the counter inputs.
  - Write: W1C semantics. Writing 1 to bit0 pulses clr_overflow; writing 1 to bit1 pulses clr_underflow.
- Register 0x03 TCNT (RO): reads tcnt. Writes ignored.
- Write timing: register fields update on the clock edge that samples the write. Outputs change 1 cycle after the write-phase edge.
- Load strobe: a TCR write with bit7=1 asserts load high for exactly one clk cycle, on the cycle after the write edge. Back-to-back LOAD writes give one pulse each, never a merged long pulse.
- Load ordering: UD, EN and TDR values written in the same TCR access are visible on outputs in the same cycle as that load pulse.
- Clear strobes: each is exactly one cycle, one cycle after the write edge. Writing 0 to a TSR bit causes no pulse. Both strobes may pulse together.
- Prescaler: 4-bit free-running counter div[3:0], incrementing every clk and wrapping 15→0.
- clk_ena generation: clk_ena is registered and equals the rising-edge detect of div[CKS], so it is a one-cycle pulse.
  - Period 2 × 2^CKS cycles: CKS=0 → every 2, 1 → 4, 2 → 8, 3 → 16.
  - clk_ena runs regardless of EN; the counter gates counting with enable.
- CKS change: the prescaler is not reset. The next clk_ena occurs on the next rising edge of the newly selected bit. No extra or glitch pulse may be created by the change itself.
- Reset mid-operation: all strobes drop immediately and the prescaler restarts at 0. The first clk_ena after release comes 2^(CKS+1) cycles later, i.e. 2 cycles with CKS=0.
- Simultaneous events:
  - TSR clear and a new counter overflow in the same cycle are resolved inside the counter; timer_ctrl only emits the strobe.
  - A TCR write setting EN=0 with LOAD=1 still produces the load pulse.

Decomposition:
- timer_pkg holds:
  - address constants ADDR_TDR=0x00, ADDR_TCR=0x01, ADDR_TSR=0x02, ADDR_TCNT=0x03;
  - bit-position constants TCR_LOAD=7, TCR_UD=5, TCR_EN=4, TCR_CKS_LSB=0, TSR_OVF=0, TSR_UDF=1.
- One sub-module, timer_prescaler:
  - inputs clk, rst_n, cks[1:0];
  - output clk_ena;
  - contains the 4-bit divider and the edge detect.

Test Plan:
- Reset: hold rst_n=0 for 5 clks, release -> all outputs 0, pready=1; reads of 0x00–0x03 return 0 (tcnt=0); first clk_ena 2 cycles after release (CKS=0).
- Prescaler: write CKS=0,1,2,3 in turn, measure 8 clk_ena periods each -> 2, 4, 8 and 16 cycles exactly, pulse width 1 cycle.
- Load sequence: write TDR=0xFD, then TCR=0xB0 -> start_counter=0xFD, up_down=1, enable=1, load high for exactly 1 cycle; TCR reads back 0x30.
- Counter integration (CKS=0, up-count from 0xFD): overflow is set after 3 clk_ena; TSR reads 0x01; writing TSR=0x01 gives one clr_overflow pulse, after which TSR reads 0x00; clr_underflow stays 0.
- Boundaries: write CKS 0→3 mid-period -> no clk_ena glitch. Write TSR=0x03 -> both clear strobes pulse together. Write to address 0x07 -> no state change, reads 0. Assert rst_n low in the same cycle as a load pulse -> load drops immediately.
